// File: rtl/sub8_share_arbiter.sv
// Round-robin arbiter time-sharing one external 8-bit ripple subtractor among NUM_REQ requesters.
// Latency: rsp_valid rises SETTLE_CYCLES+1 edges after accept; no accept until the response is taken.
// Optional macro SUB8_ARB_STATS_EN adds per-requester saturating grant counters (grant_cnt, stats_clr).
module sub8_share_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*8-1:0]   req_a,
    input  logic [NUM_REQ*8-1:0]   req_b,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [7:0]             rsp_diff,
    output logic                   rsp_borrow,
    output logic [7:0]             sub_a,
    output logic [7:0]             sub_b,
    input  logic [7:0]             sub_diff,
    input  logic                   sub_carry,
    output logic                   busy
`ifdef SUB8_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]  grant_cnt,
    input  logic                   stats_clr
`endif
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [IW-1:0] pick;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    sub_a_q, sub_a_d;
    logic [7:0]    sub_b_q, sub_b_d;
    logic [7:0]    rsp_diff_q, rsp_diff_d;
    logic          rsp_borrow_q, rsp_borrow_d;
    logic          found;
    logic          accept;
    int            idx;

    // Search downward from the farthest offset so the nearest valid at/after ptr wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (req_valid[idx[IW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IW-1:0];
            end
        end
    end

    assign accept = (state_q == IDLE) && found;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        cnt_d        = cnt_q;
        sub_a_d      = sub_a_q;
        sub_b_d      = sub_b_q;
        rsp_diff_d   = rsp_diff_q;
        rsp_borrow_d = rsp_borrow_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    sub_a_d = req_a[8*int'(pick) +: 8];
                    sub_b_d = req_b[8*int'(pick) +: 8];
                    gnt_d   = pick;
                    ptr_d   = (pick == IW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
                    // Loading the full count gives the ripple path SETTLE_CYCLES whole
                    // cycles beyond the launch cycle, hence the +1 response latency.
                    cnt_d   = 4'(SETTLE_CYCLES);
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == 4'd0) begin
                    rsp_diff_d   = sub_diff;
                    rsp_borrow_d = ~sub_carry;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready[gnt_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            gnt_q        <= '0;
            cnt_q        <= '0;
            sub_a_q      <= '0;
            sub_b_q      <= '0;
            rsp_diff_q   <= '0;
            rsp_borrow_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            cnt_q        <= cnt_d;
            sub_a_q      <= sub_a_d;
            sub_b_q      <= sub_b_d;
            rsp_diff_q   <= rsp_diff_d;
            rsp_borrow_q <= rsp_borrow_d;
        end
    end

    // Ready is gated by rst_n so every output reads zero while reset is held.
    assign req_ready  = (accept && rst_n) ? (NUM_REQ'(1) << pick) : '0;
    assign rsp_valid  = (state_q == RESP) ? (NUM_REQ'(1) << gnt_q) : '0;
    assign busy       = (state_q != IDLE);
    assign sub_a      = sub_a_q;
    assign sub_b      = sub_b_q;
    assign rsp_diff   = rsp_diff_q;
    assign rsp_borrow = rsp_borrow_q;

`ifdef SUB8_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] gcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (stats_clr) begin
                    gcnt_q[i] <= 16'h0000;
                end else if (accept && (pick == IW'(i)) && (gcnt_q[i] != 16'hFFFF)) begin
                    gcnt_q[i] <= gcnt_q[i] + 16'h0001;
                end
            end
        end
    end

    assign grant_cnt = gcnt_q;
`endif

endmodule

// File: tb/tb_sub8_share_arbiter.sv
// Directed bench for sub8_share_arbiter with a behavioural subtractor on the sub_* pins.
module tb_sub8_share_arbiter;

    localparam int NR = 4;
    localparam int SC = 2;

    logic          clk;
    logic          rst_n;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    logic [NR*8-1:0] req_a;
    logic [NR*8-1:0] req_b;
    logic [NR-1:0] rsp_valid;
    logic [NR-1:0] rsp_ready;
    logic [7:0]    rsp_diff;
    logic          rsp_borrow;
    logic [7:0]    sub_a;
    logic [7:0]    sub_b;
    logic [7:0]    sub_diff;
    logic          sub_carry;
    logic          busy;
`ifdef SUB8_ARB_STATS_EN
    logic [NR*16-1:0] grant_cnt;
    logic          stats_clr;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    sub8_share_arbiter #(.NUM_REQ(NR), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_diff(rsp_diff), .rsp_borrow(rsp_borrow),
        .sub_a(sub_a), .sub_b(sub_b),
        .sub_diff(sub_diff), .sub_carry(sub_carry),
        .busy(busy)
`ifdef SUB8_ARB_STATS_EN
        , .grant_cnt(grant_cnt), .stats_clr(stats_clr)
`endif
    );

    // Ideal subtractor: carry-out high means no borrow.
    assign sub_diff  = sub_a - sub_b;
    assign sub_carry = (sub_a >= sub_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset;
        req_valid = '0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Presents one request, waits for accept, then counts edges until rsp_valid (0 on timeout).
    task automatic run_one(input int idx, input logic [7:0] a, input logic [7:0] b, output int lat);
        bit got;
        req_a[8*idx +: 8] = a;
        req_b[8*idx +: 8] = b;
        req_valid = NR'(1) << idx;
        #1;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (req_ready[idx]) got = 1;
            else begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        req_valid = '0;
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (rsp_valid != '0) lat = k;
        end
    endtask

    task automatic wait_idle;
        for (int k = 0; k < 30 && busy; k++) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL wait_idle: busy got %b want 0", busy);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = NR'($urandom);
        req_a = $urandom; req_b = $urandom;
        rsp_ready = NR'($urandom);
        #3;
        n_cmp++;
        if ({req_ready, rsp_valid, busy, sub_a, sub_b, rsp_diff, rsp_borrow} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b vld=%b busy=%b a=%h b=%h d=%h bw=%b want all 0",
                     req_ready, rsp_valid, busy, sub_a, sub_b, rsp_diff, rsp_borrow);
        end
        req_valid = 4'b1111;
        @(posedge clk); #1;
        n_cmp++;
        if ({req_ready, busy, sub_a, sub_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_held_edge: rdy=%b busy=%b a=%h b=%h want 0", req_ready, busy, sub_a, sub_b);
        end
        req_valid = '0;
        rsp_ready = '1;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({busy, req_ready, rsp_valid} !== '0) begin
                n_fail++;
                $display("FAIL idle_after_reset cyc%0d: busy=%b rdy=%b vld=%b want 0", k, busy, req_ready, rsp_valid);
            end
        end
    endtask

    task automatic test_single;
        int lat;
        run_one(1, 8'h5A, 8'h1F, lat);
        n_cmp++;
        if (lat !== 3) begin n_fail++; $display("FAIL single_latency: got %0d want 3", lat); end
        n_cmp++;
        if (rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 0010", rsp_valid); end
        n_cmp++;
        if ({rsp_diff, rsp_borrow} !== {8'h3B, 1'b0}) begin
            n_fail++; $display("FAIL single_result: got %h/%b want 3b/0", rsp_diff, rsp_borrow);
        end
        n_cmp++;
        if ({sub_a, sub_b} !== {8'h5A, 8'h1F}) begin
            n_fail++; $display("FAIL single_operands: got %h/%h want 5a/1f", sub_a, sub_b);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({rsp_valid, busy} !== 5'b0) begin
            n_fail++; $display("FAIL single_consume: vld=%b busy=%b want 0000/0", rsp_valid, busy);
        end
    endtask

    task automatic test_borrow_wrap;
        int lat;
        run_one(0, 8'h00, 8'h01, lat);
        n_cmp++;
        if ({rsp_valid, rsp_diff, rsp_borrow} !== {4'b0001, 8'hFF, 1'b1}) begin
            n_fail++; $display("FAIL wrap_00_01: vld=%b d=%h bw=%b want 0001/ff/1", rsp_valid, rsp_diff, rsp_borrow);
        end
        @(posedge clk); #1;
        run_one(0, 8'h80, 8'h80, lat);
        n_cmp++;
        if ({rsp_valid, rsp_diff, rsp_borrow} !== {4'b0001, 8'h00, 1'b0}) begin
            n_fail++; $display("FAIL equal_80_80: vld=%b d=%h bw=%b want 0001/00/0", rsp_valid, rsp_diff, rsp_borrow);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin;
        int exp_g [6] = '{0, 1, 2, 3, 0, 1};
        logic [7:0] exp_d [4] = '{8'h10, 8'h1F, 8'h2E, 8'h3D};
        int n, last, g;
        do_reset;
        rsp_ready = '1;
        req_a = {8'h40, 8'h30, 8'h20, 8'h10};
        req_b = {8'h03, 8'h02, 8'h01, 8'h00};
        req_valid = 4'b1111;
        #1;
        n = 0; last = 0;
        for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
            if (busy) begin
                n_cmp++;
                if (req_ready !== '0) begin
                    n_fail++; $display("FAIL rr_ready_while_busy cyc%0d: got %b want 0000", cyc, req_ready);
                end
            end
            if (rsp_valid != '0) begin
                g = 0;
                for (int i = 0; i < NR; i++) if (rsp_valid[i]) g = i;
                n_cmp++;
                if (rsp_diff !== exp_d[g]) begin
                    n_fail++; $display("FAIL rr_diff req%0d: got %h want %h", g, rsp_diff, exp_d[g]);
                end
            end
            if (req_ready != '0) begin
                g = -1;
                for (int i = 0; i < NR; i++) if (req_ready[i]) g = i;
                n_cmp++;
                if (g !== exp_g[n]) begin
                    n_fail++; $display("FAIL rr_grant%0d: got %0d want %0d", n, g, exp_g[n]);
                end
                if (n > 0) begin
                    n_cmp++;
                    if (cyc - last !== SC + 3) begin
                        n_fail++; $display("FAIL rr_spacing%0d: got %0d want %0d", n, cyc - last, SC + 3);
                    end
                end
                last = cyc;
                n++;
            end
            if (n < 6) begin @(posedge clk); #1; end
        end
        n_cmp++;
        if (n !== 6) begin n_fail++; $display("FAIL rr_grant_count: got %0d want 6", n); end
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle;
    endtask

    task automatic test_backpressure_reset;
        int lat;
        rsp_ready = '0;
        run_one(2, 8'h33, 8'h11, lat);
        n_cmp++;
        if (lat !== 3) begin n_fail++; $display("FAIL bp_latency: got %0d want 3", lat); end
        req_valid = 4'b1011;
        rsp_ready = 4'b1011;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({rsp_valid, rsp_diff, rsp_borrow, req_ready, busy} !== {4'b0100, 8'h22, 1'b0, 4'b0000, 1'b1}) begin
                n_fail++;
                $display("FAIL bp_hold cyc%0d: vld=%b d=%h bw=%b rdy=%b busy=%b want 0100/22/0/0000/1",
                         k, rsp_valid, rsp_diff, rsp_borrow, req_ready, busy);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rsp_valid, busy, rsp_diff, sub_a, sub_b, req_ready} !== '0) begin
            n_fail++;
            $display("FAIL bp_async_reset: vld=%b busy=%b d=%h a=%h b=%h rdy=%b want 0",
                     rsp_valid, busy, rsp_diff, sub_a, sub_b, req_ready);
        end
        #1;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL bp_ptr_restart: rdy got %b want 0001", req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = '1;
        wait_idle;
    endtask

`ifdef SUB8_ARB_STATS_EN
    task automatic test_stats;
        int lat;
        stats_clr = 1'b0;
        do_reset;
        rsp_ready = '1;
        for (int k = 0; k < 5; k++) begin
            run_one(3, 8'h09, 8'h04, lat);
            @(posedge clk); #1;
        end
        n_cmp++;
        if (grant_cnt !== {16'd5, 48'd0}) begin
            n_fail++; $display("FAIL stats_count: got %h want 0005_0000_0000_0000", grant_cnt);
        end
        req_valid = 4'b1000;
        #1;
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        req_valid = '0;
        n_cmp++;
        if (grant_cnt[63:48] !== 16'd0) begin
            n_fail++; $display("FAIL stats_clr_priority: got %h want 0000", grant_cnt[63:48]);
        end
        wait_idle;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_a = '0;
        req_b = '0;
`ifdef SUB8_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        test_reset;
        test_single;
        test_borrow_wrap;
        test_round_robin;
        test_backpressure_reset;
`ifdef SUB8_ARB_STATS_EN
        test_stats;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
